// File: rtl/chrom_eval_pkg.sv
// Shared types and helpers for the chromosome evaluation controller.
// The optional cycle counter is enabled by defining CHROM_EVAL_PERF_EN.
package chrom_eval_pkg;

  localparam int unsigned AW_DEFAULT = 15;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRdWait,
    StSettle,
    StCheck,
    StDone,
    StRelease
  } state_e;

  function automatic logic [5:0] popcount32(input logic [DATA_W-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/chrom_eval_ctrl_if.sv
// HPS handshake, memory second-port and circuit signals of the evaluation controller.
// eval_cycles exists only when CHROM_EVAL_PERF_EN is defined.
interface chrom_eval_ctrl_if
  import chrom_eval_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT
);
  logic              start_processing_chrom;
  logic              done_processing_feedback;
  logic [DATA_W-1:0] sequences_to_process;
  logic [DATA_W-1:0] valid_mask;
  logic              ready_to_process;
  logic              done_processing_chrom;
  logic [DATA_W-1:0] error_sum;
`ifdef CHROM_EVAL_PERF_EN
  logic [DATA_W-1:0] eval_cycles;
`endif

  logic [AW-1:0]     mem_s2_address;
  logic              mem_s2_chipselect;
  logic              mem_s2_clken;
  logic              mem_s2_write;
  logic [3:0]        mem_s2_byteenable;
  logic [DATA_W-1:0] mem_s2_writedata;
  logic [DATA_W-1:0] mem_s2_readdata;

  logic [AW-1:0]     correct_mem_s2_address;
  logic              correct_mem_s2_chipselect;
  logic              correct_mem_s2_clken;
  logic              correct_mem_s2_write;
  logic [3:0]        correct_mem_s2_byteenable;
  logic [DATA_W-1:0] correct_mem_s2_writedata;
  logic [DATA_W-1:0] correct_mem_s2_readdata;

  logic [DATA_W-1:0] circuit_in;
  logic [DATA_W-1:0] circuit_out;

  // The controller is the responder; the HPS/memories/circuit side is the master.
  modport slave (
`ifdef CHROM_EVAL_PERF_EN
    output eval_cycles,
`endif
    input  start_processing_chrom, done_processing_feedback, sequences_to_process, valid_mask,
    output ready_to_process, done_processing_chrom, error_sum,
    output mem_s2_address, mem_s2_chipselect, mem_s2_clken, mem_s2_write, mem_s2_byteenable,
    output mem_s2_writedata,
    input  mem_s2_readdata,
    output correct_mem_s2_address, correct_mem_s2_chipselect, correct_mem_s2_clken,
    output correct_mem_s2_write, correct_mem_s2_byteenable, correct_mem_s2_writedata,
    input  correct_mem_s2_readdata,
    output circuit_in,
    input  circuit_out
  );

  modport master (
`ifdef CHROM_EVAL_PERF_EN
    input  eval_cycles,
`endif
    output start_processing_chrom, done_processing_feedback, sequences_to_process, valid_mask,
    input  ready_to_process, done_processing_chrom, error_sum,
    input  mem_s2_address, mem_s2_chipselect, mem_s2_clken, mem_s2_write, mem_s2_byteenable,
    input  mem_s2_writedata,
    output mem_s2_readdata,
    input  correct_mem_s2_address, correct_mem_s2_chipselect, correct_mem_s2_clken,
    input  correct_mem_s2_write, correct_mem_s2_byteenable, correct_mem_s2_writedata,
    output correct_mem_s2_readdata,
    input  circuit_in,
    output circuit_out
  );

endinterface

// File: rtl/chrom_eval_popcount.sv
// Counts the bits where the circuit response differs from the expected word,
// restricted to the bits selected by the mask.
module chrom_eval_popcount
  import chrom_eval_pkg::*;
(
  input  logic [DATA_W-1:0] actual_i,
  input  logic [DATA_W-1:0] expected_i,
  input  logic [DATA_W-1:0] mask_i,
  output logic [5:0]        count_o
);

  assign count_o = popcount32((actual_i ^ expected_i) & mask_i);

endmodule

// File: rtl/chrom_eval_ctrl.sv
// Evaluation responder: walks the stimulus/expected memories and accumulates masked
// mismatches. Defining CHROM_EVAL_PERF_EN adds the eval_cycles counter.
module chrom_eval_ctrl
  import chrom_eval_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned AW            = AW_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  chrom_eval_ctrl_if.slave bus
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES) + 1;

  state_e              state_q, state_d;
  logic [AW:0]         count_q, count_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   cin_q, cin_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [AW:0]         count_clamp;
  logic [AW:0]         idx_next;
  logic [5:0]          mismatch;
  logic                mem_en;

  // Any bit at or above AW means the request exceeds the memory depth.
  assign count_clamp = (|bus.sequences_to_process[DATA_W-1:AW]) ? {1'b1, {AW{1'b0}}}
                                                                 : {1'b0, bus.sequences_to_process[AW-1:0]};
  assign idx_next    = {1'b0, idx_q} + {{AW{1'b0}}, 1'b1};

  chrom_eval_popcount u_popcount (
    .actual_i   (bus.circuit_out),
    .expected_i (exp_q),
    .mask_i     (bus.valid_mask),
    .count_o    (mismatch)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    cin_d    = cin_q;
    exp_d    = exp_q;
    settle_d = settle_q;
    mem_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_processing_chrom) begin
          count_d = count_clamp;
          idx_d   = '0;
          sum_d   = '0;
          state_d = (count_clamp == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        mem_en  = 1'b1;
        state_d = StRdWait;
      end
      StRdWait: begin
        cin_d    = bus.mem_s2_readdata;
        exp_d    = bus.correct_mem_s2_readdata;
        settle_d = SettleW'(SETTLE_CYCLES - 1);
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == '0) state_d = StCheck;
        else                settle_d = settle_q - 1'b1;
      end
      StCheck: begin
        sum_d = sum_q + DATA_W'(mismatch);
        if (idx_next == count_q) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_next[AW-1:0];
          state_d = StFetch;
        end
      end
      StDone: begin
        if (bus.done_processing_feedback) state_d = StRelease;
      end
      StRelease: begin
        // Four-phase: both level signals must drop before a new start is accepted.
        if (!bus.done_processing_feedback && !bus.start_processing_chrom) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      cin_q    <= '0;
      exp_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      cin_q    <= cin_d;
      exp_q    <= exp_d;
      settle_q <= settle_d;
    end
  end

`ifdef CHROM_EVAL_PERF_EN
  logic [DATA_W-1:0] cycles_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q <= '0;
    end else if (state_q == StIdle && bus.start_processing_chrom) begin
      cycles_q <= '0;
    end else if (state_q inside {StFetch, StRdWait, StSettle, StCheck}) begin
      cycles_q <= cycles_q + 1'b1;
    end
  end

  assign bus.eval_cycles = cycles_q;
`endif

  assign bus.ready_to_process      = (state_q == StIdle);
  assign bus.done_processing_chrom = (state_q == StDone);
  assign bus.error_sum             = sum_q;
  assign bus.circuit_in            = cin_q;

  assign bus.mem_s2_address            = idx_q;
  assign bus.mem_s2_chipselect         = mem_en;
  assign bus.mem_s2_clken              = mem_en;
  assign bus.mem_s2_write              = 1'b0;
  assign bus.mem_s2_byteenable         = 4'hF;
  assign bus.mem_s2_writedata          = '0;
  assign bus.correct_mem_s2_address    = idx_q;
  assign bus.correct_mem_s2_chipselect = mem_en;
  assign bus.correct_mem_s2_clken      = mem_en;
  assign bus.correct_mem_s2_write      = 1'b0;
  assign bus.correct_mem_s2_byteenable = 4'hF;
  assign bus.correct_mem_s2_writedata  = '0;

endmodule

// File: tb/tb_chrom_eval_ctrl.sv
// Scoreboard bench for chrom_eval_ctrl: stimulus pushes expected run results,
// a negedge monitor pops and compares them when done rises.
module tb_chrom_eval_ctrl;

  localparam int unsigned S  = 4;
  localparam int unsigned AW = 15;

  typedef struct {
    logic [31:0] sum;
    int          cyc;
    int          reads;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic zero_mode = 1'b0;

  int total = 0;
  int bad   = 0;
  int cs_count = 0;

  exp_t sb[$];

  logic [31:0] in_mem  [0:15];
  logic [31:0] exp_mem [0:15];

  chrom_eval_ctrl_if #(.AW(AW)) bus ();

  chrom_eval_ctrl #(.SETTLE_CYCLES(S), .AW(AW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_s2_chipselect && bus.mem_s2_clken)
      bus.mem_s2_readdata <= in_mem[bus.mem_s2_address[3:0]];
    if (bus.correct_mem_s2_chipselect && bus.correct_mem_s2_clken)
      bus.correct_mem_s2_readdata <= exp_mem[bus.correct_mem_s2_address[3:0]];
  end

  assign bus.circuit_out = zero_mode ? 32'h0 : bus.circuit_in;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: tracks each run from ready falling to done rising.
  logic ready_prev = 1'b1;
  logic done_prev  = 1'b0;
  logic in_run     = 1'b0;
  int   cyc        = 0;
  int   reads      = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_run = 1'b0;
    end else begin
      if (ready_prev && !bus.ready_to_process) begin
        in_run = 1'b1;
        cyc    = 0;
        reads  = 0;
      end else if (in_run) begin
        cyc++;
      end
      if (bus.mem_s2_chipselect || bus.correct_mem_s2_chipselect) begin
        cs_count++;
        check("rd_addr", 32'(bus.mem_s2_address), reads);
        check("exp_addr", 32'(bus.correct_mem_s2_address), reads);
        check("cs_pair", 32'(bus.correct_mem_s2_chipselect), 32'(bus.mem_s2_chipselect));
        check("no_write", 32'({bus.mem_s2_write, bus.correct_mem_s2_write}), 0);
        reads++;
      end
      if (!done_prev && bus.done_processing_chrom) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(bus.done_processing_chrom), 0);
        end else begin
          e = sb.pop_front();
          check("error_sum", bus.error_sum, e.sum);
          check("done_latency", cyc, e.cyc);
          check("reads", reads, e.reads);
`ifdef CHROM_EVAL_PERF_EN
          check("eval_cycles", bus.eval_cycles, e.cyc);
`endif
        end
        in_run = 1'b0;
      end
    end
    ready_prev = bus.ready_to_process;
    done_prev  = bus.done_processing_chrom;
  end

  task automatic wait_for(input bit use_done, input logic val, input int bound,
                          input string name);
    for (int i = 0; i < bound; i++) begin
      if ((use_done ? bus.done_processing_chrom : bus.ready_to_process) === val) break;
      @(negedge clk);
    end
    check(name, 32'(use_done ? bus.done_processing_chrom : bus.ready_to_process), 32'(val));
  endtask

  task automatic run(input int n, input logic [31:0] mask, input logic [31:0] sum);
    exp_t e;
    e.sum = sum; e.cyc = n * (S + 3); e.reads = n;
    sb.push_back(e);
    bus.sequences_to_process   = n;
    bus.valid_mask             = mask;
    bus.start_processing_chrom = 1'b1;
    wait_for(1'b0, 1'b0, 10, "accept");
    bus.start_processing_chrom = 1'b0;
    wait_for(1'b1, 1'b1, 1000, "done_rise");
    bus.done_processing_feedback = 1'b1;
    wait_for(1'b1, 1'b0, 10, "done_fall");
    bus.done_processing_feedback = 1'b0;
    wait_for(1'b0, 1'b1, 10, "back_idle");
  endtask

  initial begin
    int snap;
    exp_t e;
    bus.start_processing_chrom   = 1'b0;
    bus.done_processing_feedback = 1'b0;
    bus.sequences_to_process     = '0;
    bus.valid_mask               = '0;
    for (int i = 0; i < 16; i++) begin
      in_mem[i] = '0; exp_mem[i] = '0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready_to_process), 1);
    check("rst_done", 32'(bus.done_processing_chrom), 0);
    check("rst_sum", bus.error_sum, 0);
    check("rst_cin", bus.circuit_in, 0);
    check("rst_en", 32'({bus.mem_s2_chipselect, bus.mem_s2_clken,
                         bus.correct_mem_s2_chipselect, bus.correct_mem_s2_clken}), 0);
    check("rst_addr", 32'(bus.mem_s2_address), 0);
    check("rst_be", 32'({bus.mem_s2_byteenable, bus.correct_mem_s2_byteenable}), 32'hFF);
    check("rst_wdata", bus.mem_s2_writedata | bus.correct_mem_s2_writedata, 0);
    rst = 1'b0;

    // Idle: no reads
    repeat (20) @(negedge clk);
    #1;
    check("idle_no_reads", cs_count, 0);
    check("idle_ready", 32'(bus.ready_to_process), 1);

    // Matching circuit, full mask: zero errors, 21 cycles
    in_mem[0] = 32'hDEADBEEF; in_mem[1] = 32'h0; in_mem[2] = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) exp_mem[i] = in_mem[i];
    @(negedge clk);
    run(3, 32'hFFFFFFFF, 0);

    // Circuit returns 0, mask low byte: 4 + 8
    zero_mode = 1'b1;
    exp_mem[0] = 32'h0000000F; exp_mem[1] = 32'hFFFFFFFF;
    run(2, 32'h000000FF, 12);

    // Sparse mask: 1 + 2 + 4 mismatching bits
    zero_mode = 1'b0;
    in_mem[0] = 32'h12345678; in_mem[1] = 32'h0; in_mem[2] = 32'hFFFFFFFF;
    exp_mem[0] = 32'h12345679; exp_mem[1] = 32'h00000003; exp_mem[2] = 32'h0FFFFFFF;
    run(3, 32'hF000000F, 7);

    // Zero sequences: done immediately, sum cleared, no reads
    run(0, 32'hFFFFFFFF, 0);

    // Start held high through DONE/RELEASE
    in_mem[0] = 32'h1; exp_mem[0] = 32'h0;
    e.sum = 1; e.cyc = S + 3; e.reads = 1;
    sb.push_back(e);
    bus.sequences_to_process   = 1;
    bus.valid_mask             = 32'hFFFFFFFF;
    bus.start_processing_chrom = 1'b1;
    wait_for(1'b1, 1'b1, 200, "held_done_rise");
    bus.done_processing_feedback = 1'b1;
    wait_for(1'b1, 1'b0, 10, "held_done_fall");
    bus.done_processing_feedback = 1'b0;
    #1 snap = cs_count;
    repeat (10) @(negedge clk);
    #1;
    check("held_no_ready", 32'(bus.ready_to_process), 0);
    check("held_no_done", 32'(bus.done_processing_chrom), 0);
    check("held_no_rerun", cs_count, snap);
    bus.start_processing_chrom = 1'b0;
    @(negedge clk);
    check("release_ready", 32'(bus.ready_to_process), 1);
    repeat (5) @(negedge clk);
    #1;
    check("release_no_rerun", cs_count, snap);

    // Reset during SETTLE of the fifth sequence
    for (int i = 0; i < 8; i++) begin
      in_mem[i] = 32'h11111111 * i; exp_mem[i] = in_mem[i] ^ 32'h1;
    end
    bus.sequences_to_process   = 8;
    bus.start_processing_chrom = 1'b1;
    wait_for(1'b0, 1'b0, 10, "rst_run_accept");
    bus.start_processing_chrom = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.mem_s2_chipselect && bus.mem_s2_address == 15'd4) break;
      @(negedge clk);
    end
    check("reach_seq5", 32'(bus.mem_s2_address), 4);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(bus.ready_to_process), 1);
    check("midrst_cin", bus.circuit_in, 0);
    check("midrst_sum", bus.error_sum, 0);
    check("midrst_en", 32'(bus.mem_s2_chipselect | bus.correct_mem_s2_chipselect), 0);
    rst = 1'b0;
    @(negedge clk);
    run(2, 32'hFFFFFFFF, 2);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chrom_eval_ctrl.md
# chrom_eval_ctrl

FPGA-side responder to the HPS evaluation handshake: accepts a start request, walks the input-sequence and expected-output on-chip memories through their second ports, applies each input word to the evolved circuit, and accumulates masked bit mismatches into an error sum. It sits between the HPS PIO/memory exports and the genetic circuit instance, and answers with done/ready while the HPS reads the sum.

## Interface
- SETTLE_CYCLES, 4: cycles the circuit input is held before its output is sampled (≥1)
- AW, 15: memory word-address width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_processing_chrom  in  1  HPS request, level
- done_processing_feedback  in  1  HPS acknowledge of done, level
- sequences_to_process  in  32  number of sequences to evaluate
- valid_mask  in  32  output bits that count toward error
- ready_to_process  out  1  idle and able to accept start
- done_processing_chrom  out  1  evaluation complete, error_sum valid
- error_sum  out  32  accumulated mismatch count
- mem_s2_address / correct_mem_s2_address  out  AW  read address (input / expected)
- mem_s2_chipselect, mem_s2_clken, correct_mem_s2_chipselect, correct_mem_s2_clken  out  1  read enables
- mem_s2_write, correct_mem_s2_write  out  1  tied 0
- mem_s2_byteenable, correct_mem_s2_byteenable  out  4  tied 4'hF
- mem_s2_writedata, correct_mem_s2_writedata  out  32  tied 0
- mem_s2_readdata, correct_mem_s2_readdata  in  32  read data, 1-cycle latency
- circuit_in  out  32  stimulus to evolved circuit
- circuit_out  in  32  circuit response

## Operation
- States: IDLE, FETCH, RDWAIT, SETTLE, CHECK, DONE, RELEASE.
- IDLE: ready_to_process=1. start_processing_chrom=1 → latch count = min(sequences_to_process, 2^AW), idx=0, error_sum=0, ready=0; count==0 → DONE, else FETCH.
- FETCH: both memories addressed with idx, chipselect=clken=1 (one cycle) → RDWAIT.
- RDWAIT: readdata valid; register input word to circuit_in, expected word to exp_reg → SETTLE.
- SETTLE: hold circuit_in for SETTLE_CYCLES cycles (down-counter) → CHECK.
- CHECK: error_sum += popcount((circuit_out ^ exp_reg) & valid_mask); idx+1==count → DONE, else idx++ → FETCH.
- DONE: done_processing_chrom=1, error_sum frozen; done_processing_feedback=1 → RELEASE.
- RELEASE: done=0; wait feedback=0 and start=0 → IDLE (four-phase; a held-high start never retriggers).
- start deasserting mid-run is ignored; run completes.
- Sum width 32 bits: max 32·2^15 < 2^32, no overflow handling.
- circuit_in holds its last value outside SETTLE/CHECK.

## Timing
- Reset values: ready_to_process=1, done_processing_chrom=0, error_sum=0, circuit_in=0, all memory enables 0, addresses 0.
- Per sequence: 1 (FETCH) + 1 (RDWAIT) + SETTLE_CYCLES + 1 (CHECK) = SETTLE_CYCLES+3 cycles.
- start sampled in IDLE → ready falls next edge; done rises N·(SETTLE_CYCLES+3) cycles after FETCH first entered.
- Reset mid-run: immediate return to IDLE with reset values; no memory access after reset asserts.
- Memory enables asserted only in FETCH; no writes ever issued.

## Configuration
- CHROM_EVAL_PERF_EN defined: extra output eval_cycles [31:0], cleared on start accept, increments every cycle until DONE entered, then holds; reset 0.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Package chrom_eval_pkg: state enum, AW default, DATA_W=32, popcount32 function.
- One sub-module: chrom_eval_popcount (32-bit masked-XOR popcount, combinational, 6-bit result) instantiated in CHECK path.

## Test plan
- Reset, then idle: ready=1, done=0, error_sum=0, no chipselect pulses over 20 cycles.
- count=3, circuit_out=circuit_in, expected=inputs, mask=FFFFFFFF → done after 3·7=21 cycles from FETCH (SETTLE=4), error_sum=0.
- count=2, expected={0x0000000F, 0xFFFFFFFF}, circuit returns 0, mask=0x000000FF → error_sum=4+8=12.
- count=0 → DONE next cycle, error_sum=0, no memory read issued.
- Hold start high through DONE/RELEASE, pulse feedback → done falls, stays in RELEASE until start drops, then ready=1; no second run.
- Assert reset during SETTLE of sequence 5 → next cycle ready=1, circuit_in=0, error_sum=0; new start reruns from idx 0.
